// File: rtl/data_write_buffer.sv
// Posted-write FIFO between the store path and data RAM: single-cycle store
// accept, one-word-per-cycle drain, youngest-entry forwarding for loads.
module data_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  input  logic [DATA_WIDTH-1:0]   rd_addr,
  output logic                    fwd_hit,
  output logic [DATA_WIDTH-1:0]   fwd_data,
  output logic                    ram_we,
  output logic [DATA_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wd,
  input  logic                    ram_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AW    = DATA_WIDTH - 2;

  logic [AW-1:0]         addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic is_empty, is_full, push, pop;

  // Byte-offset bits are irrelevant for word entries.
  logic unused_ok;
  assign unused_ok = &{1'b0, wr_addr[1:0], rd_addr[1:0]};

  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == CNT_W'(DEPTH));
    // Nothing is presented to RAM during a reset cycle, so reset never races a write.
    ram_we   = !is_empty && !rst;
    pop      = ram_we && ram_ready;
    push     = wr_en && (!is_full || pop) && !rst;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Contents are never cleared; validity comes solely from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= wr_addr[DATA_WIDTH-1:2];
      data_mem[tail_q] <= wr_data;
    end
  end

  assign full  = is_full;
  assign empty = is_empty;
  assign count = count_q;

  always_comb begin
    ram_addr = '0;
    ram_wd   = '0;
    if (ram_we) begin
      ram_addr = {addr_mem[head_q], 2'b00};
      ram_wd   = data_mem[head_q];
    end
  end

  // Entries are viewed by age (0 = oldest at head) so the youngest match is
  // found relative to tail, independent of physical index across the wrap.
  logic                  age_hit  [DEPTH];
  logic [DATA_WIDTH-1:0] age_data [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [PTR_W-1:0] idx;
      assign idx          = head_q + PTR_W'(gi);
      assign age_hit[gi]  = (CNT_W'(gi) < count_q) &&
                            (addr_mem[idx] == rd_addr[DATA_WIDTH-1:2]);
      assign age_data[gi] = data_mem[idx];
    end
  endgenerate

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_hit[i]) begin
        fwd_hit  = 1'b1;
        fwd_data = age_data[i];
      end
    end
  end

endmodule
